// File: rtl/song_sequencer_pkg.sv
`default_nettype none
// ============================================================
// Package : song_sequencer_pkg
// Brief   : play-control codes, note ranges, ROM entry layout, FSM states
// Revision: 1.0
// ============================================================
package song_sequencer_pkg;

   localparam int c_DEF_NOTE_W    = 5;
   localparam int c_DEF_ADDR_W    = 6;
   localparam int c_DEF_DUR_W     = 3;
   localparam int c_DEF_NUM_SONGS = 4;
   localparam int c_DEF_TICK_DIV  = 12_500_000;

   localparam logic [1:0] c_SSTOP  = 2'd0;
   localparam logic [1:0] c_SPLAY  = 2'd1;
   localparam logic [1:0] c_SPAUSE = 2'd2;

   // Note codes: 0 silence, 1-7 low, 8-14 middle, 15-21 high octave.
   localparam int c_NOTE_REST      = 0;
   localparam int c_NOTE_LOW_BASE  = 1;
   localparam int c_NOTE_MID_BASE  = 8;
   localparam int c_NOTE_HIGH_BASE = 15;

   // ROM entry = {note, dur}; a zero duration marks the end of a song.
   localparam int c_END_MARK = 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/song_rom.sv
`default_nettype none
// ============================================================
// Module  : song_rom
// Brief   : combinational {note, dur} lookup for every stored song
// Revision: 1.0
// ============================================================
module song_rom
   import song_sequencer_pkg::*;
#(
   parameter int NOTE_W = c_DEF_NOTE_W,
   parameter int ADDR_W = c_DEF_ADDR_W,
   parameter int DUR_W  = c_DEF_DUR_W,
   parameter int SEL_W  = 2
)(
   input  logic [SEL_W-1:0]  i_song_idx,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [NOTE_W-1:0] o_note,
   output logic [DUR_W-1:0]  o_dur
);

   logic [NOTE_W+DUR_W-1:0] w_entry;

   function automatic logic [NOTE_W+DUR_W-1:0] ent(input int note, input int dur);
      return {NOTE_W'(note), DUR_W'(dur)};
   endfunction

   // Addresses past a song's last entry fall through to the end marker.
   always_comb begin
      w_entry = ent(c_NOTE_REST, c_END_MARK);
      case (int'(i_song_idx))
         0: case (int'(i_addr))
               0:       w_entry = ent(c_NOTE_LOW_BASE, 2);
               1:       w_entry = ent(c_NOTE_LOW_BASE + 4, 1);
               2:       w_entry = ent(c_NOTE_REST, 1);
               3:       w_entry = ent(c_NOTE_MID_BASE, 3);
               default: ;
            endcase
         // Fills the whole address space so the song ends on the address limit.
         1: w_entry = ent(c_NOTE_HIGH_BASE + 6, 1);
         2: case (int'(i_addr))
               0:       w_entry = ent(c_NOTE_MID_BASE, 1);
               1:       w_entry = ent(c_NOTE_MID_BASE + 2, 2);
               2:       w_entry = ent(c_NOTE_MID_BASE + 4, 1);
               3:       w_entry = ent(c_NOTE_REST, 1);
               4:       w_entry = ent(c_NOTE_HIGH_BASE, 4);
               5:       w_entry = ent(c_NOTE_HIGH_BASE + 6, 7);
               default: ;
            endcase
         default: ;
      endcase
   end

   assign {o_note, o_dur} = w_entry;

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================
// Module  : song_sequencer
// Brief   : multi-song, tempo-aware note sequencer for auto-play
// Revision: 1.0
// ============================================================
module song_sequencer
   import song_sequencer_pkg::*;
#(
   parameter  int NOTE_W    = c_DEF_NOTE_W,
   parameter  int ADDR_W    = c_DEF_ADDR_W,
   parameter  int DUR_W     = c_DEF_DUR_W,
   parameter  int NUM_SONGS = c_DEF_NUM_SONGS,
   parameter  int TICK_DIV  = c_DEF_TICK_DIV,
   localparam int SEL_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        state,
   input  logic [SEL_W-1:0]  song_sel,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] cnt,
   output logic [NOTE_W-1:0] music,
   output logic              busy,
   output logic              done
);

   localparam int              TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] c_TICK_MAX = TICK_W'(TICK_DIV - 1);

   seq_state_t        r_fsm;
   logic [ADDR_W-1:0] r_cnt;
   logic [NOTE_W-1:0] r_music;
   logic [NOTE_W-1:0] r_cur_note;
   logic [DUR_W-1:0]  r_dur;
   logic [TICK_W-1:0] r_tick;
   logic [SEL_W-1:0]  r_song;
   logic              r_busy;
   logic              r_done;

   logic [SEL_W-1:0]  w_first_song;
   logic [ADDR_W-1:0] w_next_addr;
   logic [NOTE_W-1:0] w_first_note;
   logic [NOTE_W-1:0] w_next_note;
   logic [DUR_W-1:0]  w_first_dur;
   logic [DUR_W-1:0]  w_next_dur;
   logic              w_tick;
   logic              w_last;

   // In IDLE the live selection addresses entry 0; afterwards the latched song does.
   assign w_first_song = (r_fsm == S_IDLE) ? song_sel : r_song;
   assign w_next_addr  = r_cnt + 1'b1;
   assign w_tick       = (r_tick == c_TICK_MAX);
   assign w_last       = (r_cnt == '1) || (w_next_dur == DUR_W'(c_END_MARK));

   song_rom #(
      .NOTE_W (NOTE_W),
      .ADDR_W (ADDR_W),
      .DUR_W  (DUR_W),
      .SEL_W  (SEL_W)
   ) u_rom_first (
      .i_song_idx (w_first_song),
      .i_addr     ('0),
      .o_note     (w_first_note),
      .o_dur      (w_first_dur)
   );

   song_rom #(
      .NOTE_W (NOTE_W),
      .ADDR_W (ADDR_W),
      .DUR_W  (DUR_W),
      .SEL_W  (SEL_W)
   ) u_rom_next (
      .i_song_idx (r_song),
      .i_addr     (w_next_addr),
      .o_note     (w_next_note),
      .o_dur      (w_next_dur)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fsm      <= S_IDLE;
         r_cnt      <= '0;
         r_music    <= '0;
         r_cur_note <= '0;
         r_dur      <= '0;
         r_tick     <= '0;
         r_song     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (state == c_SSTOP) begin
            r_fsm   <= S_IDLE;
            r_cnt   <= '0;
            r_music <= '0;
            r_dur   <= '0;
            r_tick  <= '0;
            r_busy  <= 1'b0;
         end else begin
            case (r_fsm)
               S_IDLE: begin
                  if (state == c_SPLAY) begin
                     r_song <= song_sel;
                     r_cnt  <= '0;
                     if (w_first_dur == DUR_W'(c_END_MARK)) begin
                        // Empty song: nothing to play, so loop mode simply stays idle.
                        if (!loop_en) begin
                           r_fsm  <= S_DONE;
                           r_done <= 1'b1;
                        end
                     end else begin
                        r_fsm      <= S_PLAY;
                        r_busy     <= 1'b1;
                        r_music    <= w_first_note;
                        r_cur_note <= w_first_note;
                        r_dur      <= w_first_dur;
                        r_tick     <= '0;
                     end
                  end
               end
               S_PLAY: begin
                  if (state == c_SPLAY) begin
                     if (!w_tick) begin
                        r_tick <= r_tick + 1'b1;
                     end else begin
                        r_tick <= '0;
                        if (r_dur > DUR_W'(1)) begin
                           r_dur <= r_dur - 1'b1;
                        end else if (!w_last) begin
                           r_cnt      <= w_next_addr;
                           r_music    <= w_next_note;
                           r_cur_note <= w_next_note;
                           r_dur      <= w_next_dur;
                        end else if (loop_en) begin
                           r_cnt      <= '0;
                           r_music    <= w_first_note;
                           r_cur_note <= w_first_note;
                           r_dur      <= w_first_dur;
                        end else begin
                           r_fsm   <= S_DONE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                           r_music <= '0;
                           r_dur   <= '0;
                        end
                     end
                  end else begin
                     r_fsm   <= S_PAUSE;
                     r_music <= '0;
                  end
               end
               S_PAUSE: begin
                  if (state == c_SPLAY) begin
                     r_fsm   <= S_PLAY;
                     r_music <= r_cur_note;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign cnt   = r_cnt;
   assign music = r_music;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule
`default_nettype wire
